// File: rtl/skid_stage.sv
// Elastic two-entry skid slice: registered valid/ready on both sides,
// full 1 beat/cycle throughput, strict FIFO order.
module skid_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] skid, skid_n;
   logic [WIDTH-1:0] data_n;
   logic             valid_n;
   logic             ready_n;
   logic [1:0]       count_n;
   logic             acc;
   logic             pop;

   assign acc = s_valid & s_ready;
   assign pop = m_valid & m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         skid    <= '0;
         m_data  <= '0;
         m_valid <= 1'b0;
         s_ready <= 1'b0;
         count   <= 2'd0;
      end else begin
         state   <= state_n;
         skid    <= skid_n;
         m_data  <= data_n;
         m_valid <= valid_n;
         s_ready <= ready_n;
         count   <= count_n;
      end
   end

   always_comb begin
      state_n = state;
      skid_n  = skid;
      data_n  = m_data;
      unique case (state)
         EMPTY: begin
            if (acc) begin
               data_n  = s_data;
               state_n = BUSY;
            end
         end
         BUSY: begin
            if (acc && pop) begin
               data_n = s_data;
            end else if (acc) begin
               skid_n  = s_data;
               state_n = FULL;
            end else if (pop) begin
               state_n = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               data_n  = skid;
               state_n = BUSY;
            end
         end
         default: state_n = EMPTY;
      endcase
   end

   // Every output flop is loaded from the next state, so none of them
   // has a combinational path from s_valid or m_ready.
   always_comb begin
      valid_n = (state_n != EMPTY);
      ready_n = (state_n != FULL);
      count_n = 2'd0;
      unique case (state_n)
         EMPTY:   count_n = 2'd0;
         BUSY:    count_n = 2'd1;
         FULL:    count_n = 2'd2;
         default: count_n = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_skid_stage.sv
// Scoreboard bench for skid_stage: directed scenarios plus a random soak
// checked against a queue model of accepted-but-not-delivered beats.
module tb_skid_stage;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         s_valid;
   logic         s_ready;
   logic [W-1:0] s_data;
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_data;
   logic [1:0]   count;

   int tests;
   int fails;
   int bad;
   bit post_rst;
   bit armed;
   bit stall_prev;
   logic [W-1:0] prev_data;
   logic [W-1:0] q[$];

   skid_stage #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .count   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Ready may only appear after the first edge seen out of reset.
   always @(posedge clk or negedge rst_n) armed = rst_n;

   // Input side: every accepted beat becomes an expected output.
   always @(posedge clk) begin
      if (rst_n && s_valid && s_ready) q.push_back(s_data);
   end

   // Output side: occupancy, flags, stall stability and ordered data.
   always @(negedge clk) begin
      logic [W-1:0] exp;
      if (!rst_n) begin
         q.delete();
         stall_prev = 1'b0;
         chk("rst_m_valid", W'(m_valid), '0);
         chk("rst_m_data", m_data, '0);
         chk("rst_s_ready", W'(s_ready), '0);
         chk("rst_count", W'(count), '0);
      end else begin
         chk("count", W'(count), W'(q.size()));
         chk("m_valid", W'(m_valid), W'(q.size() != 0));
         chk("s_ready", W'(s_ready), W'(armed && q.size() < 2));
         if (stall_prev) chk("stall_hold", m_data, prev_data);
         if (m_valid && m_ready) begin
            if (q.size() == 0) begin
               chk("pop_empty", m_data, 'x);
            end else begin
               exp = q.pop_front();
               chk("data", m_data, exp);
            end
            if (post_rst && (m_data == 32'h11 || m_data == 32'h22))
               bad++;
         end
         stall_prev = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   task automatic drive(input logic sv, input logic [W-1:0] d,
                        input logic mr);
      @(posedge clk);
      #1;
      s_valid = sv;
      s_data  = d;
      m_ready = mr;
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      bad      = 0;
      post_rst = 1'b0;
      rst_n    = 1'b1;
      s_valid  = 1'b1;
      s_data   = 32'hDEADBEEF;
      m_ready  = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("exit_s_ready_low", W'(s_ready), '0);
      chk("exit_count", W'(count), '0);
      drive(0, '0, 1);
      @(negedge clk);
      chk("exit_s_ready_high", W'(s_ready), 1);
      chk("exit_no_accept", W'(count), '0);
      drive(0, '0, 1);

      for (int i = 1; i <= 8; i++) begin
         drive(1, W'(i), 1);
         @(negedge clk);
         if (i > 1) begin
            chk("stream_data", m_data, W'(i - 1));
            chk("stream_count", W'(count), 1);
            chk("stream_ready", W'(s_ready), 1);
         end
      end
      drive(0, '0, 1);
      @(negedge clk);
      chk("stream_last", m_data, 32'h8);
      drive(0, '0, 1);
      @(negedge clk);
      chk("drain_valid", W'(m_valid), '0);
      chk("drain_count", W'(count), '0);
      chk("drain_data", m_data, 32'h8);

      drive(1, 32'hA, 0);
      drive(1, 32'hB, 0);
      drive(1, 32'hC, 0);
      @(negedge clk);
      chk("bp_data", m_data, 32'hA);
      chk("bp_count", W'(count), 2);
      chk("bp_ready", W'(s_ready), '0);
      drive(1, 32'hC, 0);
      @(negedge clk);
      chk("bp_hold", m_data, 32'hA);
      chk("bp_no_c", W'(count), 2);
      drive(1, 32'hC, 1);
      drive(1, 32'hC, 1);
      @(negedge clk);
      chk("bp_b", m_data, 32'hB);
      chk("bp_ready_back", W'(s_ready), 1);
      drive(0, '0, 1);
      @(negedge clk);
      chk("bp_c", m_data, 32'hC);
      drive(0, '0, 0);

      drive(1, 32'h11, 0);
      drive(1, 32'h22, 0);
      drive(0, '0, 1);
      @(negedge clk);
      chk("full_count", W'(count), 2);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_m_valid", W'(m_valid), '0);
      chk("arst_s_ready", W'(s_ready), '0);
      chk("arst_count", W'(count), '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      post_rst = 1'b1;
      repeat (4) drive(0, '0, 1);

      for (int i = 0; i < 10000; i++) begin
         drive(1'($urandom_range(0, 1)), W'($urandom),
               1'($urandom_range(0, 1)));
      end
      repeat (4) drive(0, '0, 1);
      @(negedge clk);
      chk("final_empty", W'(q.size()), '0);
      chk("no_stale", W'(bad), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
